// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM states, parity
// encodings and the 16x sampling constants.
package uart_pkg;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } rx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_MID = 8;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO with registered read port; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int P_DATA_W = 8,
    parameter int P_DEPTH  = 16
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic                       push,
    input  logic [P_DATA_W-1:0]        push_data,
    input  logic                       pop,
    output logic [P_DATA_W-1:0]        rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(P_DEPTH):0]   count,
    output logic                       drop
);

    localparam int AW = $clog2(P_DEPTH);
    localparam int CW = AW + 1;

    logic [P_DATA_W-1:0] mem [P_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                pop_ok;
    logic                push_ok;

    assign full    = (count == CW'(P_DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && !push_ok;

    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop_ok;
            if (pop_ok) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // When full with push+pop, the read sees the old word before it is overwritten.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// 16x-oversampling UART receiver with majority vote, sticky status and RX FIFO.
// Define UART_RX_ERR_CNT_EN to add saturating frame/parity/overrun event counters.
//
// state    | meaning
// S_INIT   | waiting for P_IDLE_BITS bit-times of continuous high
// S_IDLE   | line idle, waiting for a falling edge
// S_START  | start bit; re-checked at mid-bit to reject glitches
// S_DATA   | shifting in data bits, LSB first
// S_PARITY | sampling and checking the parity bit
// S_STOP   | sampling the stop bit; push word or flag framing error
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int P_DATA_W     = 8,
    parameter int P_FIFO_DEPTH = 16,
    parameter int P_IDLE_BITS  = 10,
    parameter int P_DIV_W      = 16
) (
    input  logic                            CLK,
    input  logic                            reset,
    input  logic                            serial_in,
    input  logic [P_DIV_W-1:0]              baud_div,
    input  logic [1:0]                      parity_mode,
    input  logic                            rd_en,
    output logic [P_DATA_W-1:0]             rd_data,
    output logic                            rd_valid,
    output logic                            fifo_full,
    output logic                            fifo_empty,
    output logic [$clog2(P_FIFO_DEPTH):0]   fifo_count,
    input  logic                            err_clr,
    output logic                            frame_err,
    output logic                            parity_err,
    output logic                            overrun_err,
    output logic                            break_det
`ifdef UART_RX_ERR_CNT_EN
    ,
    output logic [7:0]                      frame_err_cnt,
    output logic [7:0]                      parity_err_cnt,
    output logic [7:0]                      overrun_cnt
`endif
);

    localparam int PH_W   = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(P_DATA_W + 1);
    localparam int IDLE_W = $clog2(P_IDLE_BITS + 1);

    logic                rx_meta, rx_s, rx_prev, fall;
    logic [P_DIV_W-1:0]  div_live, div_lat, reload, tick_cnt;
    logic [PH_W-1:0]     phase, phase_nxt;
    logic                tick, mid_pre, mid, mid_post, bit_end;
    logic                phase_rst, in_frame;
    rx_state_t           state;
    logic [IDLE_W-1:0]   idle_left;
    logic [BIT_W-1:0]    bit_left;
    logic [P_DATA_W-1:0] shreg;
    logic [1:0]          par_lat;
    logic                s_a, s_b, vote, par_en, exp_par;
    logic                push, fifo_drop, frame_ev, break_ev, parity_ev;

    always_ff @(posedge CLK) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= serial_in;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign fall      = rx_prev && !rx_s;
    assign div_live  = (baud_div == '0) ? P_DIV_W'(1) : baud_div;
    assign in_frame  = (state != S_INIT) && (state != S_IDLE);
    assign reload    = (in_frame ? div_lat : div_live) - 1'b1;
    assign tick      = (tick_cnt == '0);
    assign phase_nxt = phase + 1'b1;
    assign mid_pre   = tick && (phase_nxt == PH_W'(SAMPLE_MID - 1));
    assign mid       = tick && (phase_nxt == PH_W'(SAMPLE_MID));
    assign mid_post  = tick && (phase_nxt == PH_W'(SAMPLE_MID + 1));
    assign bit_end   = tick && (phase_nxt == '0);
    assign phase_rst = ((state == S_IDLE) && fall) || ((state == S_INIT) && !rx_s);

    // Phase 0 is the synchronised start edge; events fire when phase_nxt reaches N.
    always_ff @(posedge CLK) begin
        if (reset) begin
            tick_cnt <= '0;
            phase    <= '0;
        end else if (phase_rst) begin
            tick_cnt <= reload;
            phase    <= '0;
        end else if (tick) begin
            tick_cnt <= reload;
            phase    <= phase_nxt;
        end else begin
            tick_cnt <= tick_cnt - 1'b1;
        end
    end

    assign vote      = maj3(s_a, s_b, rx_s);
    assign par_en    = (par_lat == PAR_ODD) || (par_lat == PAR_EVEN);
    assign exp_par   = (par_lat == PAR_ODD) ? ~^shreg : ^shreg;
    assign push      = (state == S_STOP) && mid_post && vote;
    assign frame_ev  = (state == S_STOP) && mid_post && !vote;
    assign break_ev  = frame_ev && (shreg == '0);
    assign parity_ev = (state == S_PARITY) && mid_post && (vote != exp_par);

    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= S_INIT;
            idle_left <= IDLE_W'(P_IDLE_BITS);
            bit_left  <= '0;
            shreg     <= '0;
            s_a       <= 1'b1;
            s_b       <= 1'b1;
            div_lat   <= P_DIV_W'(1);
            par_lat   <= PAR_NONE;
        end else begin
            if (mid_pre) s_a <= rx_s;
            if (mid)     s_b <= rx_s;
            case (state)
                S_INIT: begin
                    if (!rx_s) begin
                        idle_left <= IDLE_W'(P_IDLE_BITS);
                    end else if (bit_end) begin
                        if (idle_left <= IDLE_W'(1)) state <= S_IDLE;
                        else                         idle_left <= idle_left - 1'b1;
                    end
                end
                S_IDLE: begin
                    if (fall) begin
                        state   <= S_START;
                        div_lat <= div_live;
                        par_lat <= parity_mode;
                    end
                end
                S_START: begin
                    if (mid && rx_s) begin
                        state <= S_IDLE;
                    end else if (bit_end) begin
                        state    <= S_DATA;
                        bit_left <= BIT_W'(P_DATA_W);
                    end
                end
                S_DATA: begin
                    if (mid_post) shreg <= {vote, shreg[P_DATA_W-1:1]};
                    if (bit_end) begin
                        if (bit_left == BIT_W'(1)) state <= par_en ? S_PARITY : S_STOP;
                        else                       bit_left <= bit_left - 1'b1;
                    end
                end
                S_PARITY: begin
                    if (bit_end) state <= S_STOP;
                end
                S_STOP: begin
                    if (mid_post) begin
                        if (vote) begin
                            state <= S_IDLE;
                        end else begin
                            state     <= S_INIT;
                            idle_left <= IDLE_W'(P_IDLE_BITS);
                        end
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    // Set wins over a same-cycle clear.
    always_ff @(posedge CLK) begin
        if (reset) begin
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
            break_det   <= 1'b0;
        end else begin
            frame_err   <= frame_ev  || (frame_err   && !err_clr);
            parity_err  <= parity_ev || (parity_err  && !err_clr);
            overrun_err <= fifo_drop || (overrun_err && !err_clr);
            break_det   <= break_ev  || (break_det   && !err_clr);
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    function automatic logic [7:0] cnt_next(input logic [7:0] c, input logic ev, input logic clr);
        if (clr)                   return ev ? 8'd1 : 8'd0;
        else if (ev && c != 8'hFF) return c + 8'd1;
        else                       return c;
    endfunction

    always_ff @(posedge CLK) begin
        if (reset) begin
            frame_err_cnt  <= '0;
            parity_err_cnt <= '0;
            overrun_cnt    <= '0;
        end else begin
            frame_err_cnt  <= cnt_next(frame_err_cnt, frame_ev, err_clr);
            parity_err_cnt <= cnt_next(parity_err_cnt, parity_ev, err_clr);
            overrun_cnt    <= cnt_next(overrun_cnt, fifo_drop, err_clr);
        end
    end
`endif

    uart_rx_fifo #(
        .P_DATA_W (P_DATA_W),
        .P_DEPTH  (P_FIFO_DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .reset     (reset),
        .push      (push),
        .push_data (shreg),
        .pop       (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .drop      (fifo_drop)
    );

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: baud_div=2 (32 cycles per bit), 4-entry FIFO.
// Expected values are hand-computed; optional counters checked when UART_RX_ERR_CNT_EN is set.
module tb_uart_rx_os;

    localparam int BIT = 32;

    logic        CLK = 1'b0;
    logic        reset;
    logic        serial_in;
    logic [15:0] baud_div;
    logic [1:0]  parity_mode;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        fifo_full;
    logic        fifo_empty;
    logic [2:0]  fifo_count;
    logic        err_clr;
    logic        frame_err;
    logic        parity_err;
    logic        overrun_err;
    logic        break_det;
`ifdef UART_RX_ERR_CNT_EN
    logic [7:0]  frame_err_cnt;
    logic [7:0]  parity_err_cnt;
    logic [7:0]  overrun_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    uart_rx_os #(
        .P_DATA_W     (8),
        .P_FIFO_DEPTH (4),
        .P_IDLE_BITS  (10),
        .P_DIV_W      (16)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .serial_in   (serial_in),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .fifo_count  (fifo_count),
        .err_clr     (err_clr),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun_err (overrun_err),
        .break_det   (break_det)
`ifdef UART_RX_ERR_CNT_EN
        ,
        .frame_err_cnt  (frame_err_cnt),
        .parity_err_cnt (parity_err_cnt),
        .overrun_cnt    (overrun_cnt)
`endif
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A glitched bit flips the line for one 1/16 phase around the middle sample only.
    task automatic drive_bit(input logic v, input bit glitch);
        serial_in = v;
        if (glitch) begin
            repeat (16) step();
            serial_in = ~v;
            repeat (2) step();
            serial_in = v;
            repeat (14) step();
        end else begin
            repeat (BIT) step();
        end
    endtask

    task automatic send_head(input logic [7:0] d, input bit par_en, input logic par_bit, input int glitch_bit);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i], i == glitch_bit);
        if (par_en) drive_bit(par_bit, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_en, input logic par_bit, input logic stop_bit);
        send_head(d, par_en, par_bit, -1);
        drive_bit(stop_bit, 1'b0);
        serial_in = 1'b1;
        repeat (BIT) step();
    endtask

    task automatic read_expect(input string tag, input logic [7:0] exp);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check({tag, "_valid"}, rd_valid, 1);
        check(tag, rd_data, exp);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        serial_in   = 1'b1;
        baud_div    = 16'd2;
        parity_mode = 2'b00;
        rd_en       = 1'b0;
        err_clr     = 1'b0;
        repeat (4) step();
        check("rst_empty", fifo_empty, 1);
        check("rst_count", fifo_count, 0);
        check("rst_full", fifo_full, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_data", rd_data, 0);
        check("rst_flags", {frame_err, parity_err, overrun_err, break_det}, 0);
        reset = 1'b0;
        repeat (400) step();

        // T1 basic 8N1, with exact push latency on the first frame
        send_head(8'h55, 1'b0, 1'b0, -1);
        serial_in = 1'b1;
        repeat (20) step();
        check("t1_pre_push_count", fifo_count, 0);
        step();
        check("t1_push_count", fifo_count, 1);
        check("t1_push_empty", fifo_empty, 0);
        repeat (11 + BIT) step();
        send_frame(8'hA3, 1'b0, 1'b0, 1'b1);
        check("t1_count2", fifo_count, 2);
        read_expect("t1_rd0", 8'h55);
        step();
        check("t1_valid_pulse", rd_valid, 0);
        read_expect("t1_rd1", 8'hA3);
        check("t1_empty", fifo_empty, 1);
        check("t1_flags", {frame_err, parity_err, overrun_err, break_det}, 0);

        // T2 parity
        parity_mode = 2'b10;
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        check("t2_even_ok", parity_err, 0);
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        check("t2_even_bad", parity_err, 1);
        check("t2_count", fifo_count, 2);
`ifdef UART_RX_ERR_CNT_EN
        check("t2_par_cnt", parity_err_cnt, 1);
`endif
        pulse_clr();
        check("t2_clr", parity_err, 0);
        parity_mode = 2'b01;
        send_frame(8'h03, 1'b1, 1'b1, 1'b1);
        check("t2_odd_ok", parity_err, 0);
        send_frame(8'h03, 1'b1, 1'b0, 1'b1);
        check("t2_odd_bad", parity_err, 1);
        parity_mode = 2'b00;
        read_expect("t2_rd0", 8'h07);
        read_expect("t2_rd1", 8'h07);
        read_expect("t2_rd2", 8'h03);
        read_expect("t2_rd3", 8'h03);
        pulse_clr();
        check("t2_frame", frame_err, 0);

        // T3 false start and mid-bit glitch
        serial_in = 1'b0;
        repeat (6) step();
        serial_in = 1'b1;
        repeat (2 * BIT) step();
        check("t3_false_start", fifo_count, 0);
        check("t3_false_flags", {frame_err, parity_err, break_det}, 0);
        send_head(8'hA5, 1'b0, 1'b0, 3);
        drive_bit(1'b1, 1'b0);
        repeat (BIT) step();
        check("t3_glitch_count", fifo_count, 1);
        read_expect("t3_glitch_data", 8'hA5);

        // T4 overrun and push+pop while full
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b1);
        check("t4_full", fifo_full, 1);
        check("t4_no_ovr_yet", overrun_err, 0);
        send_frame(8'h05, 1'b0, 1'b0, 1'b1);
        check("t4_overrun", overrun_err, 1);
        check("t4_count", fifo_count, 4);
`ifdef UART_RX_ERR_CNT_EN
        check("t4_ovr_cnt", overrun_cnt, 1);
`endif
        pulse_clr();
        check("t4_clr", overrun_err, 0);
        send_head(8'h06, 1'b0, 1'b0, -1);
        serial_in = 1'b1;
        repeat (20) step();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("t4_pp_valid", rd_valid, 1);
        check("t4_pp_data", rd_data, 8'h01);
        check("t4_pp_count", fifo_count, 4);
        check("t4_pp_no_ovr", overrun_err, 0);
        repeat (11 + BIT) step();
        read_expect("t4_rd2", 8'h02);
        read_expect("t4_rd3", 8'h03);
        read_expect("t4_rd4", 8'h04);
        read_expect("t4_rd6", 8'h06);
        check("t4_empty", fifo_empty, 1);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("t4_empty_rd_valid", rd_valid, 0);
        check("t4_empty_rd_hold", rd_data, 8'h06);

        // T5 break, then idle requirement before the next frame
        serial_in = 1'b0;
        repeat (20 * BIT) step();
        serial_in = 1'b1;
        repeat (4) step();
        check("t5_frame", frame_err, 1);
        check("t5_break", break_det, 1);
        check("t5_no_push", fifo_count, 0);
`ifdef UART_RX_ERR_CNT_EN
        check("t5_frame_cnt", frame_err_cnt, 1);
`endif
        repeat (5 * BIT) step();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        check("t5_ignored_in_init", fifo_count, 0);
        repeat (11 * BIT) step();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        check("t5_after_idle", fifo_count, 1);
        read_expect("t5_rd", 8'h3C);
        pulse_clr();
        check("t5_clr", {frame_err, break_det}, 0);

        // T6 frame error without break, then reset mid-frame
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0);
        check("t6_frame", frame_err, 1);
        check("t6_no_break", break_det, 0);
        check("t6_count", fifo_count, 1);
        repeat (11 * BIT) step();
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        serial_in = 1'b0;
        repeat (16) step();
        reset = 1'b1;
        serial_in = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        check("t6_rst_empty", fifo_empty, 1);
        check("t6_rst_count", fifo_count, 0);
        check("t6_rst_flags", {frame_err, parity_err, overrun_err, break_det}, 0);
        check("t6_rst_data", rd_data, 0);
`ifdef UART_RX_ERR_CNT_EN
        check("t6_rst_cnts", {frame_err_cnt, parity_err_cnt, overrun_cnt}, 0);
`endif
        repeat (400) step();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        check("t6_count_after", fifo_count, 1);
        read_expect("t6_rd", 8'h5A);
        check("t6_flags_after", {frame_err, parity_err, overrun_err, break_det}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
